// File: rtl/integer_alu_seq_if.sv
// Issue/result bundle between CPU decode and the integer ALU.
// master = issuing stage, slave = ALU.
interface integer_alu_seq_if #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           op;
  logic [WIDTH-1:0]     dina;
  logic [IMM_WIDTH-1:0] dinb;
  logic                 out_valid;
  logic [WIDTH-1:0]     dout;
  logic                 flag_cf;
  logic                 flag_zf;
  logic                 flag_of;

  modport master (
    output in_valid, op, dina, dinb,
    input  in_ready, out_valid, dout, flag_cf, flag_zf, flag_of
  );

  modport slave (
    input  in_valid, op, dina, dinb,
    output in_ready, out_valid, dout, flag_cf, flag_zf, flag_of
  );
endinterface

// File: rtl/integer_alu_seq.sv
// Integer ALU with registered CF/ZF/OF and a 1-bit/cycle serial shifter.
// Define INTEGER_ALU_ROTATE_EN to build ROR/ROL (opcodes 12/13); otherwise they act as MOV_R_R.
//
// state | meaning
// IDLE  | ready; single-cycle ops and shifts by 0/1 complete here
// SHIFT | serial shift in progress, cnt = shift steps still to do
module integer_alu_seq #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 8,
  parameter int SHAMT_W   = 5
) (
  input logic             CLK,
  input logic             RST_N,
  integer_alu_seq_if.slave bus
);

  localparam logic [3:0] OP_MOV_RR = 4'd0;
  localparam logic [3:0] OP_MOV_RC = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_ADC    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_SBB    = 4'd5;
  localparam logic [3:0] OP_INC    = 4'd6;
  localparam logic [3:0] OP_AND    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_XOR    = 4'd9;
  localparam logic [3:0] OP_SHR    = 4'd10;
  localparam logic [3:0] OP_SHL    = 4'd11;
`ifdef INTEGER_ALU_ROTATE_EN
  localparam logic [3:0] OP_ROR    = 4'd12;
  localparam logic [3:0] OP_ROL    = 4'd13;
`endif

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t               state, state_nx;
  logic                 in_ready;
  logic                 accept;
  logic [WIDTH-1:0]     b_ext;
  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;
  logic                 long_shift;

  logic [WIDTH-1:0]     res;
  logic                 res_cf;
  logic                 res_zf;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       first_step;
  logic [WIDTH:0]       next_step;

  logic [WIDTH-1:0]     shreg;
  logic [SHAMT_W-1:0]   cnt;
  logic [3:0]           sh_op;
  logic                 of_pend;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     dout_q;
  logic                 cf_q;
  logic                 zf_q;
  logic                 of_q;

  // One shift step: {bit moved out, new value}
  function automatic logic [WIDTH:0] step1(input logic [3:0] sop, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    r = {v[0], 1'b0, v[WIDTH-1:1]};
    case (sop)
      OP_SHL: r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
`ifdef INTEGER_ALU_ROTATE_EN
      OP_ROR: r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ROL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
`endif
      default: ;
    endcase
    return r;
  endfunction

  assign accept = bus.in_valid & in_ready;
  assign b_ext  = WIDTH'(bus.dinb);
  assign shamt  = bus.dinb[SHAMT_W-1:0];

`ifdef INTEGER_ALU_ROTATE_EN
  assign is_shift = (bus.op == OP_SHR) | (bus.op == OP_SHL) |
                    (bus.op == OP_ROR) | (bus.op == OP_ROL);
`else
  assign is_shift = (bus.op == OP_SHR) | (bus.op == OP_SHL);
`endif
  // Shifts by 0 or 1 finish in IDLE; the first step of a longer shift happens at accept
  assign long_shift = is_shift & (shamt > SHAMT_W'(1));

  assign first_step = step1(bus.op, bus.dina);
  assign next_step  = step1(sh_op, shreg);

  always_comb begin
    sum    = '0;
    res    = bus.dina;
    res_cf = cf_q;
    res_zf = zf_q;
    case (bus.op)
      OP_MOV_RC: res = b_ext;
      OP_ADD: begin
        sum    = {1'b0, bus.dina} + {1'b0, b_ext};
        res    = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_zf = ~|sum[WIDTH-1:0];
      end
      OP_ADC: begin
        sum    = {1'b0, bus.dina} + {1'b0, b_ext} + (WIDTH+1)'(cf_q);
        res    = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_zf = ~|sum[WIDTH-1:0];
      end
      OP_SUB: begin
        sum    = {1'b0, bus.dina} - {1'b0, b_ext};
        res    = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_zf = ~|sum[WIDTH-1:0];
      end
      OP_SBB: begin
        sum    = {1'b0, bus.dina} - {1'b0, b_ext} - (WIDTH+1)'(cf_q);
        res    = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_zf = ~|sum[WIDTH-1:0];
      end
      OP_INC: begin
        res    = (bus.dina == b_ext) ? '0 : bus.dina + WIDTH'(1);
        res_cf = 1'b0;
        res_zf = (bus.dina == b_ext) | (&bus.dina);
      end
      OP_AND: begin
        res    = bus.dina & b_ext;
        res_cf = 1'b0;
        res_zf = ~|(bus.dina & b_ext);
      end
      OP_OR: begin
        res    = bus.dina | b_ext;
        res_cf = 1'b0;
        res_zf = ~|(bus.dina | b_ext);
      end
      OP_XOR: begin
        res    = bus.dina ^ b_ext;
        res_cf = 1'b0;
        res_zf = ~|(bus.dina ^ b_ext);
      end
      default: begin
        if (is_shift) begin
          if (shamt == '0) begin
            res_zf = ~|bus.dina;
          end else begin
            res    = first_step[WIDTH-1:0];
            res_cf = first_step[WIDTH];
            res_zf = ~|first_step[WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept && long_shift) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == SHAMT_W'(1))   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      of_pend     <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      sh_op       <= OP_SHR;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        if (long_shift) begin
          shreg   <= first_step[WIDTH-1:0];
          cnt     <= shamt - SHAMT_W'(1);
          sh_op   <= bus.op;
          of_pend <= bus.dina[0];
        end else begin
          dout_q      <= res;
          cf_q        <= res_cf;
          zf_q        <= res_zf;
          of_q        <= bus.dina[0];
          out_valid_q <= 1'b1;
        end
      end else if (state == ST_SHIFT) begin
        shreg <= next_step[WIDTH-1:0];
        cnt   <= cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          dout_q      <= next_step[WIDTH-1:0];
          cf_q        <= next_step[WIDTH];
          zf_q        <= ~|next_step[WIDTH-1:0];
          of_q        <= of_pend;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.flag_cf   = cf_q;
  assign bus.flag_zf   = zf_q;
  assign bus.flag_of   = of_q;

endmodule

// File: tb/tb_integer_alu_seq.sv
// Directed self-checking bench for integer_alu_seq; rotate expectations follow INTEGER_ALU_ROTATE_EN.
module tb_integer_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  integer_alu_seq_if #(.WIDTH(32), .IMM_WIDTH(8)) bus ();

  integer_alu_seq #(.WIDTH(32), .IMM_WIDTH(8), .SHAMT_W(5)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one op, checks the result one cycle later, returns at a negedge.
  task automatic op1(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [7:0] b,
                     input logic [31:0] e_dout, input logic e_cf, input logic e_zf, input logic e_of);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.dina     = a;
    bus.dinb     = b;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".dout"}, bus.dout, e_dout);
    chk({tag, ".cf"}, 32'(bus.flag_cf), 32'(e_cf));
    chk({tag, ".zf"}, 32'(bus.flag_zf), 32'(e_zf));
    chk({tag, ".of"}, 32'(bus.flag_of), 32'(e_of));
  endtask

  // Long shift: returns at the negedge where out_valid is seen, reports the latency in cycles.
  task automatic shift_wait(input logic [3:0] op, input logic [31:0] a, input logic [7:0] n, output int lat);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.dina     = a;
    bus.dinb     = n;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) break;
      @(posedge clk);
    end
  endtask

  initial begin
    int  lat;
    logic seen;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 4'd0;
    bus.dina     = '0;
    bus.dinb     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.dout",      bus.dout, 32'd0);
    chk("rst.flags",     32'({bus.flag_cf, bus.flag_zf, bus.flag_of}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op1("add_wrap", 4'd2, 32'hFFFF_FFFF, 8'h01, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    op1("adc",      4'd3, 32'd5,         8'h00, 32'd6,         1'b0, 1'b0, 1'b1);
    op1("sub",      4'd4, 32'd3,         8'h05, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
    op1("sbb",      4'd5, 32'd10,        8'h02, 32'd7,         1'b0, 1'b0, 1'b0);
    op1("inc_eq",   4'd6, 32'd7,         8'h07, 32'd0,         1'b0, 1'b1, 1'b1);
    op1("inc_ne",   4'd6, 32'd6,         8'h07, 32'd7,         1'b0, 1'b0, 1'b0);
    op1("inc_wrap", 4'd6, 32'hFFFF_FFFF, 8'h05, 32'd0,         1'b0, 1'b1, 1'b1);
    op1("and",      4'd7, 32'hF0F0_00FF, 8'h3C, 32'h0000_003C, 1'b0, 1'b0, 1'b1);
    op1("or",       4'd8, 32'hF0F0_00FF, 8'h3C, 32'hF0F0_00FF, 1'b0, 1'b0, 1'b1);
    op1("xor",      4'd9, 32'hF0F0_00FF, 8'h3C, 32'hF0F0_00C3, 1'b0, 1'b0, 1'b1);
    op1("sub_cf",   4'd4, 32'd0,         8'h01, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    op1("mov_rr",   4'd0, 32'd0,         8'h00, 32'd0,         1'b1, 1'b0, 1'b0);
    op1("mov_rc",   4'd1, 32'd1,         8'h80, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
`ifdef INTEGER_ALU_ROTATE_EN
    op1("rol1",     4'd13, 32'h8000_0000, 8'h01, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
`else
    op1("rol1",     4'd13, 32'h8000_0000, 8'h01, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
`endif
    op1("rsv15",    4'd15, 32'h0000_00A5, 8'h11, 32'h0000_00A5, 1'b1, 1'b0, 1'b1);

    // SHR by 4 with an ignored issue attempt while busy
    bus.in_valid = 1'b1;
    bus.op       = 4'd10;
    bus.dina     = 32'h8000_0001;
    bus.dinb     = 8'd4;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("shr4.c1.in_ready", 32'(bus.in_ready), 32'd0);
    chk("shr4.c1.out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("shr4.c2.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.op       = 4'd1;
    bus.dina     = 32'd0;
    bus.dinb     = 8'h55;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("shr4.c3.in_ready", 32'(bus.in_ready), 32'd0);
    chk("shr4.c3.out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("shr4.c4.out_valid", 32'(bus.out_valid), 32'd1);
    chk("shr4.c4.in_ready", 32'(bus.in_ready), 32'd1);
    chk("shr4.dout", bus.dout, 32'h0800_0000);
    chk("shr4.cf", 32'(bus.flag_cf), 32'd0);
    chk("shr4.of", 32'(bus.flag_of), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("shr4.c5.out_valid", 32'(bus.out_valid), 32'd0);
    chk("shr4.c5.dout", bus.dout, 32'h0800_0000);

    op1("shl1", 4'd11, 32'h8000_0001, 8'd1, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    op1("shl0", 4'd11, 32'h0000_1234, 8'd0, 32'h0000_1234, 1'b1, 1'b0, 1'b0);

    shift_wait(4'd11, 32'd3, 8'd31, lat);
    chk("shl31.latency", 32'(lat), 32'd31);
    chk("shl31.dout", bus.dout, 32'h8000_0000);
    chk("shl31.cf", 32'(bus.flag_cf), 32'd1);
    @(negedge clk);

    shift_wait(4'd10, 32'd1, 8'd2, lat);
    chk("shr2.latency", 32'(lat), 32'd2);
    chk("shr2.dout", bus.dout, 32'd0);
    chk("shr2.cf", 32'(bus.flag_cf), 32'd0);
    chk("shr2.zf", 32'(bus.flag_zf), 32'd1);
    @(negedge clk);

    // Shift count taken mod 32: 33 behaves as 1
    op1("shr33", 4'd10, 32'h0000_0003, 8'd33, 32'h0000_0001, 1'b1, 1'b0, 1'b1);

    // Back-to-back MOV_R_C
    bus.in_valid = 1'b1;
    bus.op       = 4'd1;
    bus.dinb     = 8'd1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b1.out_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b1.dout", bus.dout, 32'd1);
    bus.dinb = 8'd2;
    @(posedge clk);
    @(negedge clk);
    chk("b2b2.out_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b2.dout", bus.dout, 32'd2);
    bus.dinb = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b3.out_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b3.dout", bus.dout, 32'd3);
    chk("b2b3.cf", 32'(bus.flag_cf), 32'd1);

    // Reset in the middle of SHR by 20
    bus.in_valid = 1'b1;
    bus.op       = 4'd10;
    bus.dina     = 32'hFFFF_FFFF;
    bus.dinb     = 8'd20;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid.busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid.dout", bus.dout, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid.no_out_valid", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
